// File: rtl/biquad_bank_sched.sv
// Time-multiplexed Direct Form I biquad bank sharing one multiplier/accumulator.
// Define BIQUAD_BANK_SAT_EN to clamp results instead of wrapping.
module biquad_bank_sched #(
    parameter int NUM_BANDS  = 16,
    parameter int WIDTH      = 24,
    parameter int SHIFT      = 20,
    parameter int COEF_WIDTH = 32,
    localparam int BW        = $clog2(NUM_BANDS)
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  sample_valid_in,
    input  logic [WIDTH-1:0]      sample_in,
    input  logic                  coef_we_in,
    input  logic [BW-1:0]         coef_band_in,
    input  logic [2:0]            coef_sel_in,
    input  logic [COEF_WIDTH-1:0] coef_data_in,
    output logic                  busy_out,
    output logic                  band_valid_out,
    output logic [BW-1:0]         band_idx_out,
    output logic [WIDTH-1:0]      band_sample_out,
    output logic                  frame_done_out,
    output logic                  overrun_out
);

    typedef enum logic [1:0] {IDLE, FETCH, MAC, WB} state_t;

    state_t state_q, state_d;

    logic [BW-1:0]                band_q;
    logic [2:0]                   tap_q;
    logic signed [WIDTH-1:0]      x_q, x1_q, x2_q;
    logic signed [WIDTH-1:0]      y1_q [NUM_BANDS];
    logic signed [WIDTH-1:0]      y2_q [NUM_BANDS];
    logic signed [COEF_WIDTH-1:0] coef_q [NUM_BANDS][5];
    logic signed [COEF_WIDTH-1:0] w_q [5];
    logic signed [WIDTH-1:0]      wy1_q, wy2_q;
    logic signed [63:0]           acc_q, acc_d;
    logic signed [63:0]           prod, term;
    logic signed [COEF_WIDTH-1:0] cf;
    logic signed [WIDTH-1:0]      op;
    logic                         sub;
    logic [WIDTH-1:0]             res_w;
    logic                         valid_q, done_q, ovr_q;
    logic [BW-1:0]                idx_q;
    logic [WIDTH-1:0]             smp_q;
    logic                         last_band, last_tap, coef_wr;

    assign last_band = (band_q == BW'(NUM_BANDS - 1));
    assign last_tap  = (tap_q == 3'd4);
    assign coef_wr   = coef_we_in && (coef_sel_in < 3'd5)
                       && (32'(coef_band_in) < NUM_BANDS);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (sample_valid_in) state_d = FETCH;
            FETCH:   state_d = MAC;
            MAC:     if (last_tap) state_d = WB;
            WB:      state_d = last_band ? IDLE : FETCH;
            default: state_d = IDLE;
        endcase
    end

    // Tap order: b0*x, b1*x1, b2*x2, then the two subtracted feedback terms.
    always_comb begin
        cf  = '0;
        op  = '0;
        sub = 1'b0;
        case (tap_q)
            3'd0: begin cf = w_q[0]; op = x_q;  end
            3'd1: begin cf = w_q[1]; op = x1_q; end
            3'd2: begin cf = w_q[2]; op = x2_q; end
            3'd3: begin cf = w_q[3]; op = wy1_q; sub = 1'b1; end
            3'd4: begin cf = w_q[4]; op = wy2_q; sub = 1'b1; end
            default: ;
        endcase
        prod  = 64'(cf) * 64'(op);
        term  = prod >>> SHIFT;
        acc_d = sub ? (acc_q - term) : (acc_q + term);
    end

`ifdef BIQUAD_BANK_SAT_EN
    localparam logic signed [63:0] SAT_HI = (64'sd1 <<< (WIDTH - 1)) - 64'sd1;
    localparam logic signed [63:0] SAT_LO = -(64'sd1 <<< (WIDTH - 1));

    always_comb begin
        if (acc_d > SAT_HI)      res_w = SAT_HI[WIDTH-1:0];
        else if (acc_d < SAT_LO) res_w = SAT_LO[WIDTH-1:0];
        else                     res_w = acc_d[WIDTH-1:0];
    end
`else
    assign res_w = acc_d[WIDTH-1:0];
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            band_q  <= '0;
            tap_q   <= '0;
            x_q     <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            wy1_q   <= '0;
            wy2_q   <= '0;
            acc_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            idx_q   <= '0;
            smp_q   <= '0;
            for (int s = 0; s < 5; s++) w_q[s] <= '0;
            for (int b = 0; b < NUM_BANDS; b++) begin
                y1_q[b] <= '0;
                y2_q[b] <= '0;
                for (int s = 0; s < 5; s++) coef_q[b][s] <= '0;
            end
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= sample_valid_in && (state_q != IDLE);
            if (coef_wr) coef_q[coef_band_in][coef_sel_in] <= coef_data_in;
            unique case (state_q)
                IDLE: begin
                    if (sample_valid_in) begin
                        x_q    <= sample_in;
                        band_q <= '0;
                    end
                end
                FETCH: begin
                    for (int s = 0; s < 5; s++) w_q[s] <= coef_q[band_q][s];
                    wy1_q <= y1_q[band_q];
                    wy2_q <= y2_q[band_q];
                    acc_q <= '0;
                    tap_q <= '0;
                end
                MAC: begin
                    acc_q <= acc_d;
                    tap_q <= tap_q + 3'd1;
                    // Register the result on the final tap so it is
                    // presented for exactly the WB cycle.
                    if (last_tap) begin
                        valid_q <= 1'b1;
                        done_q  <= last_band;
                        idx_q   <= band_q;
                        smp_q   <= res_w;
                    end
                end
                WB: begin
                    y2_q[band_q] <= y1_q[band_q];
                    y1_q[band_q] <= smp_q;
                    if (last_band) begin
                        x2_q <= x1_q;
                        x1_q <= x_q;
                    end else begin
                        band_q <= band_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_out        = (state_q != IDLE);
    assign band_valid_out  = valid_q;
    assign band_idx_out    = idx_q;
    assign band_sample_out = smp_q;
    assign frame_done_out  = done_q;
    assign overrun_out     = ovr_q;

endmodule

// File: tb/tb_biquad_bank_sched.sv
// Directed bench for biquad_bank_sched with a 4-band bank.
// Cycle 0 is the strobe cycle; cycle n is observed at the n-th falling edge after it.
module tb_biquad_bank_sched;

    localparam int NB = 4;
    localparam int W  = 24;
    localparam int CW = 32;
    localparam logic [CW-1:0] ONE = 32'h0010_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sample_valid_in;
    logic [W-1:0]  sample_in;
    logic          coef_we_in;
    logic [1:0]    coef_band_in;
    logic [2:0]    coef_sel_in;
    logic [CW-1:0] coef_data_in;
    logic          busy_out, band_valid_out, frame_done_out, overrun_out;
    logic [1:0]    band_idx_out;
    logic [W-1:0]  band_sample_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] res [NB];
    int vcyc [NB];
    int done_cyc, done_cnt, vcnt, ov_cnt, busy_last;

    always #5 clk = ~clk;

    biquad_bank_sched #(
        .NUM_BANDS(NB), .WIDTH(W), .SHIFT(20), .COEF_WIDTH(CW)
    ) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .sample_valid_in(sample_valid_in),
        .sample_in(sample_in),
        .coef_we_in(coef_we_in),
        .coef_band_in(coef_band_in),
        .coef_sel_in(coef_sel_in),
        .coef_data_in(coef_data_in),
        .busy_out(busy_out),
        .band_valid_out(band_valid_out),
        .band_idx_out(band_idx_out),
        .band_sample_out(band_sample_out),
        .frame_done_out(frame_done_out),
        .overrun_out(overrun_out)
    );

    task automatic do_reset();
        rst_n = 1'b0;
        sample_valid_in = 1'b0;
        sample_in = '0;
        coef_we_in = 1'b0;
        coef_band_in = '0;
        coef_sel_in = '0;
        coef_data_in = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic write_coef(input int b, input int s, input logic [CW-1:0] d);
        @(negedge clk);
        coef_we_in = 1'b1;
        coef_band_in = 2'(b);
        coef_sel_in = 3'(s);
        coef_data_in = d;
        @(negedge clk);
        coef_we_in = 1'b0;
    endtask

    // One frame, observed for a fixed 32 cycles, with an optional extra
    // strobe and an optional coefficient write injected at given cycles.
    task automatic run_frame(input logic [W-1:0] smp,
                             input int ov_cyc, input logic [W-1:0] ov_smp,
                             input int wr_cyc, input int wr_band,
                             input int wr_sel, input logic [CW-1:0] wr_data);
        for (int b = 0; b < NB; b++) begin
            res[b] = 'x;
            vcyc[b] = -1;
        end
        done_cyc = -1; done_cnt = 0; vcnt = 0; ov_cnt = 0; busy_last = -1;
        @(negedge clk);
        sample_valid_in = 1'b1;
        sample_in = smp;
        for (int cyc = 1; cyc <= 32; cyc++) begin
            @(negedge clk);
            sample_valid_in = 1'b0;
            coef_we_in = 1'b0;
            if (band_valid_out === 1'b1) begin
                vcnt++;
                res[band_idx_out] = band_sample_out;
                vcyc[band_idx_out] = cyc;
            end
            if (frame_done_out === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (overrun_out === 1'b1) ov_cnt++;
            if (busy_out === 1'b1) busy_last = cyc;
            if (cyc == ov_cyc) begin
                sample_valid_in = 1'b1;
                sample_in = ov_smp;
            end
            if (cyc == wr_cyc) begin
                coef_we_in = 1'b1;
                coef_band_in = 2'(wr_band);
                coef_sel_in = 3'(wr_sel);
                coef_data_in = wr_data;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({busy_out, band_valid_out, frame_done_out, overrun_out} !== 4'b0
            || band_idx_out !== 2'd0 || band_sample_out !== 24'd0) begin
            n_errors++;
            $display("FAIL reset_idle: got busy=%b v=%b d=%b o=%b idx=%0d s=%0h expected all 0",
                     busy_out, band_valid_out, frame_done_out, overrun_out,
                     band_idx_out, band_sample_out);
        end
        write_coef(0, 0, ONE);
        @(negedge clk);
        sample_valid_in = 1'b1;
        sample_in = 24'd1000;
        @(negedge clk);
        sample_valid_in = 1'b0;
        repeat (9) @(negedge clk);
        n_checks++;
        if (busy_out !== 1'b1 || band_sample_out !== 24'd1000) begin
            n_errors++;
            $display("FAIL reset_preframe: got busy=%b s=%0d expected busy=1 s=1000",
                     busy_out, band_sample_out);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy_out, band_valid_out, frame_done_out, overrun_out} !== 4'b0
            || band_idx_out !== 2'd0 || band_sample_out !== 24'd0) begin
            n_errors++;
            $display("FAIL reset_midframe: got busy=%b v=%b d=%b o=%b idx=%0d s=%0h expected all 0",
                     busy_out, band_valid_out, frame_done_out, overrun_out,
                     band_idx_out, band_sample_out);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_frame(24'd1000, -1, '0, -1, 0, 0, '0);
        for (int b = 0; b < NB; b++) begin
            n_checks++;
            if (res[b] !== 24'd0) begin
                n_errors++;
                $display("FAIL reset_zero_b%0d: got %0h expected 0", b, res[b]);
            end
        end
        n_checks++;
        if (vcnt != NB || done_cyc != 28) begin
            n_errors++;
            $display("FAIL reset_frame: got valids=%0d done@%0d expected 4 and 28",
                     vcnt, done_cyc);
        end
    endtask

    task automatic test_passthrough();
        logic [W-1:0] e [NB] = '{24'd1000, 24'd0, 24'd0, 24'd0};
        do_reset();
        write_coef(0, 0, ONE);
        write_coef(1, 5, ONE);
        run_frame(24'd1000, -1, '0, -1, 0, 0, '0);
        for (int b = 0; b < NB; b++) begin
            n_checks++;
            if (res[b] !== e[b] || vcyc[b] != 7 + 7 * b) begin
                n_errors++;
                $display("FAIL pass_b%0d: got %0d @%0d expected %0d @%0d",
                         b, res[b], vcyc[b], e[b], 7 + 7 * b);
            end
        end
        n_checks++;
        if (done_cyc != 28 || done_cnt != 1 || busy_last != 28) begin
            n_errors++;
            $display("FAIL pass_timing: got done@%0d x%0d busy_last=%0d expected 28 x1 28",
                     done_cyc, done_cnt, busy_last);
        end
    endtask

    task automatic test_delay();
        logic [W-1:0] s [3] = '{24'd500, 24'd600, 24'd700};
        logic [W-1:0] e [3] = '{24'd0, 24'd0, 24'd500};
        do_reset();
        write_coef(1, 2, ONE);
        for (int f = 0; f < 3; f++) begin
            run_frame(s[f], -1, '0, -1, 0, 0, '0);
            n_checks++;
            if (res[1] !== e[f] || res[0] !== 24'd0) begin
                n_errors++;
                $display("FAIL delay_f%0d: got b1=%0d b0=%0d expected b1=%0d b0=0",
                         f, res[1], res[0], e[f]);
            end
        end
    endtask

    task automatic test_feedback();
        logic [W-1:0] s  [4] = '{24'd1024, 24'd0, 24'd0, 24'd0};
        logic [W-1:0] e2 [4] = '{24'd1024, 24'd512, 24'd256, 24'd128};
        logic [W-1:0] e3 [4] = '{24'd1024, 24'd0, 24'd1024, 24'd0};
        do_reset();
        write_coef(2, 0, ONE);
        write_coef(2, 3, 32'hFFF8_0000);
        write_coef(3, 0, ONE);
        write_coef(3, 4, 32'hFFF0_0000);
        for (int f = 0; f < 4; f++) begin
            run_frame(s[f], -1, '0, -1, 0, 0, '0);
            n_checks++;
            if (res[2] !== e2[f] || res[3] !== e3[f]) begin
                n_errors++;
                $display("FAIL feedback_f%0d: got b2=%0d b3=%0d expected b2=%0d b3=%0d",
                         f, res[2], res[3], e2[f], e3[f]);
            end
        end
    endtask

    task automatic test_saturation();
`ifdef BIQUAD_BANK_SAT_EN
        logic [W-1:0] e [2] = '{24'h7FFFFF, 24'h800000};
`else
        logic [W-1:0] e [2] = '{24'hFFFFF8, 24'h000000};
`endif
        logic [W-1:0] s [2] = '{24'h7FFFFF, 24'h800000};
        do_reset();
        write_coef(0, 0, 32'h0080_0000);
        for (int f = 0; f < 2; f++) begin
            run_frame(s[f], -1, '0, -1, 0, 0, '0);
            n_checks++;
            if (res[0] !== e[f]) begin
                n_errors++;
                $display("FAIL sat_f%0d: got %0h expected %0h", f, res[0], e[f]);
            end
        end
    endtask

    task automatic test_overrun();
        do_reset();
        write_coef(0, 0, ONE);
        write_coef(1, 1, ONE);
        run_frame(24'd100, 10, 24'd999, -1, 0, 0, '0);
        n_checks++;
        if (ov_cnt != 1 || busy_last != 28 || res[0] !== 24'd100 || res[1] !== 24'd0) begin
            n_errors++;
            $display("FAIL overrun_f0: got ov=%0d busy_last=%0d b0=%0d b1=%0d expected 1 28 100 0",
                     ov_cnt, busy_last, res[0], res[1]);
        end
        run_frame(24'd300, -1, '0, -1, 0, 0, '0);
        n_checks++;
        if (ov_cnt != 0 || res[0] !== 24'd300 || res[1] !== 24'd100) begin
            n_errors++;
            $display("FAIL overrun_f1: got ov=%0d b0=%0d b1=%0d expected 0 300 100",
                     ov_cnt, res[0], res[1]);
        end
    endtask

    task automatic test_back_to_back();
        run_frame(24'd5, 28, 24'd77, -1, 0, 0, '0);
        n_checks++;
        if (ov_cnt != 1 || busy_last != 28 || res[0] !== 24'd5 || res[1] !== 24'd300) begin
            n_errors++;
            $display("FAIL b2b_edge_drop: got ov=%0d busy_last=%0d b0=%0d b1=%0d expected 1 28 5 300",
                     ov_cnt, busy_last, res[0], res[1]);
        end
        run_frame(24'd7, 29, 24'd8, -1, 0, 0, '0);
        n_checks++;
        if (ov_cnt != 0 || busy_last != 32 || res[0] !== 24'd7 || res[1] !== 24'd5) begin
            n_errors++;
            $display("FAIL b2b_accept: got ov=%0d busy_last=%0d b0=%0d b1=%0d expected 0 32 7 5",
                     ov_cnt, busy_last, res[0], res[1]);
        end
        repeat (30) @(negedge clk);
        n_checks++;
        if (busy_out !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_idle: got busy=%b expected 0", busy_out);
        end
        run_frame(24'd9, -1, '0, -1, 0, 0, '0);
        n_checks++;
        if (res[0] !== 24'd9 || res[1] !== 24'd8) begin
            n_errors++;
            $display("FAIL b2b_history: got b0=%0d b1=%0d expected 9 8", res[0], res[1]);
        end
    endtask

    task automatic test_midframe_write();
        do_reset();
        run_frame(24'd400, -1, '0, 10, 3, 0, ONE);
        n_checks++;
        if (res[3] !== 24'd400 || res[0] !== 24'd0) begin
            n_errors++;
            $display("FAIL midwr_future: got b3=%0d b0=%0d expected 400 0", res[3], res[0]);
        end
        run_frame(24'd800, -1, '0, 10, 0, 0, ONE);
        n_checks++;
        if (res[0] !== 24'd0 || res[3] !== 24'd800) begin
            n_errors++;
            $display("FAIL midwr_past: got b0=%0d b3=%0d expected 0 800", res[0], res[3]);
        end
        run_frame(24'd50, -1, '0, 8, 1, 0, ONE);
        n_checks++;
        if (res[0] !== 24'd50 || res[1] !== 24'd0) begin
            n_errors++;
            $display("FAIL midwr_fetch: got b0=%0d b1=%0d expected 50 0", res[0], res[1]);
        end
        run_frame(24'd70, -1, '0, -1, 0, 0, '0);
        n_checks++;
        if (res[1] !== 24'd70 || res[0] !== 24'd70) begin
            n_errors++;
            $display("FAIL midwr_next: got b1=%0d b0=%0d expected 70 70", res[1], res[0]);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_delay();
        test_feedback();
        test_saturation();
        test_overrun();
        test_back_to_back();
        test_midframe_write();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
